mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the fetch requester (IF, in the FD stage) and the data requester (load/store from the X stage) of the 3-stage core.
- Issues at most one memory transaction at a time and tracks which requester owns an outstanding read.
- Routes read data back to the owner and produces the pipeline stall that freezes PC/FD/X while any requester is waiting.
- Data side has priority; a streak counter keeps fetch from starving.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/starve_counter.sv | 36 +++
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 tb/tb_mem_port_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory port arbiter: requester ownership, FSM states
// and byte-mask width helpers.
package mem_port_arbiter_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_WAIT_RD = 1'b1
  } state_e;

  localparam int unsigned StreakW = 4;

  function automatic int unsigned mask_width(input int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating streak counter: counts consecutive data grants taken while fetch waits,
// so the arbiter can force a fetch grant once the streak reaches MAX.
module starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [StreakW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != StreakW'(MAX))) begin
      cnt_d = cnt_q + StreakW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat = (cnt_q == StreakW'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store, tracking
// the owner of the outstanding read and raising the pipeline stall while anyone waits.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [DW/8-1:0] d_wmask,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW/8-1:0] mem_wmask,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall
);

  localparam int unsigned MaskW = mask_width(DW);

  state_e state_q, state_d;
  owner_e owner_q, owner_d;

  logic window;
  logic sel_d, sel_if;
  logic grant;
  logic streak_sat;

  // A read response arriving this cycle frees the port for a zero-bubble follow-on issue.
  assign window = (state_q == S_IDLE) || mem_rvalid;
  assign sel_d  = d_req && !(if_req && streak_sat);
  assign sel_if = !sel_d && if_req;

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_wmask = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_n && window && (d_req || if_req)) begin
      mem_req = 1'b1;
      if (sel_d) begin
        mem_we    = d_we;
        mem_wmask = d_we ? d_wmask : MaskW'(0);
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end else begin
        mem_addr = if_addr;
      end
    end
  end

  assign grant  = mem_req && mem_ready;
  assign d_gnt  = grant && sel_d;
  assign if_gnt = grant && sel_if;

  assign if_rvalid = rst_n && mem_rvalid && (state_q == S_WAIT_RD) && (owner_q == OWN_IF);
  assign d_rvalid  = rst_n && mem_rvalid && (state_q == S_WAIT_RD) && (owner_q == OWN_D);
  assign if_rdata  = rst_n ? mem_rdata : '0;
  assign d_rdata   = rst_n ? mem_rdata : '0;

  assign stall = rst_n && ((if_req && !if_gnt) || (d_req && !d_gnt) ||
                           ((state_q == S_WAIT_RD) && !mem_rvalid));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if ((state_q == S_WAIT_RD) && mem_rvalid) begin
      state_d = S_IDLE;
    end
    if (grant) begin
      if (sel_d && d_we) begin
        state_d = S_IDLE;
      end else begin
        state_d = S_WAIT_RD;
        owner_d = sel_d ? OWN_D : OWN_IF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= OWN_IF;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  starve_counter #(
    .MAX (MAX_D_STREAK)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (d_gnt && if_req),
    .clr   (if_gnt || !if_req),
    .sat   (streak_sat)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1ns after the rising edge and
// outputs are checked on the falling edge against hand-computed values.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we;
  logic [3:0]    d_wmask;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_req, mem_we;
  logic [3:0]    mem_wmask;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready, mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          stall;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW           (AW),
    .DW           (DW),
    .MAX_D_STREAK (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_wmask    (d_wmask),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_wmask  (mem_wmask),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .stall      (stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic exp_dg [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic exp_ig [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b0; d_we = 1'b0; d_wmask = 4'h0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset cycle: every output forced low even with a pending fetch.
    to_sample();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_if_gnt", 32'(if_gnt), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    next_cycle();

    // Fetch only, then back-to-back fetch on the response cycle.
    rst_n = 1'b1;
    to_sample();
    check("f0_if_gnt", 32'(if_gnt), 32'd1);
    check("f0_mem_addr", mem_addr, 32'h100);
    check("f0_mem_we", 32'(mem_we), 32'd0);
    check("f0_stall", 32'(stall), 32'd0);
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 32'h13; if_addr = 32'h104;
    to_sample();
    check("f1_if_rvalid", 32'(if_rvalid), 32'd1);
    check("f1_if_rdata", if_rdata, 32'h13);
    check("f1_if_gnt", 32'(if_gnt), 32'd1);
    check("f1_mem_addr", mem_addr, 32'h104);
    check("f1_stall", 32'(stall), 32'd0);
    next_cycle();
    if_req = 1'b0; mem_rdata = 32'h17;
    to_sample();
    check("f2_if_rvalid", 32'(if_rvalid), 32'd1);
    check("f2_mem_req", 32'(mem_req), 32'd0);
    next_cycle();
    // Stray response while idle.
    to_sample();
    check("idle_if_rvalid", 32'(if_rvalid), 32'd0);
    check("idle_d_rvalid", 32'(d_rvalid), 32'd0);
    next_cycle();

    // Simultaneous fetch and load: data wins, fetch issues on the load response.
    mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h108; d_req = 1'b1; d_addr = 32'h2000;
    to_sample();
    check("s0_d_gnt", 32'(d_gnt), 32'd1);
    check("s0_if_gnt", 32'(if_gnt), 32'd0);
    check("s0_stall", 32'(stall), 32'd1);
    check("s0_mem_addr", mem_addr, 32'h2000);
    check("s0_mem_wmask", 32'(mem_wmask), 32'd0);
    next_cycle();
    d_req = 1'b0;
    to_sample();
    check("s1_mem_req", 32'(mem_req), 32'd0);
    check("s1_stall", 32'(stall), 32'd1);
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE0001;
    to_sample();
    check("s2_d_rvalid", 32'(d_rvalid), 32'd1);
    check("s2_d_rdata", d_rdata, 32'hCAFE0001);
    check("s2_if_rvalid", 32'(if_rvalid), 32'd0);
    check("s2_if_gnt", 32'(if_gnt), 32'd1);
    check("s2_mem_addr", mem_addr, 32'h108);
    check("s2_stall", 32'(stall), 32'd0);
    next_cycle();
    if_req = 1'b0; mem_rdata = 32'h55;
    to_sample();
    check("s3_if_rvalid", 32'(if_rvalid), 32'd1);
    check("s3_stall", 32'(stall), 32'd0);
    next_cycle();

    // Starvation guard: stores stream while fetch waits.
    mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h10C;
    d_req = 1'b1; d_we = 1'b1; d_wmask = 4'hF; d_addr = 32'h2100; d_wdata = 32'h1234;
    for (int i = 0; i < 7; i++) begin
      mem_rvalid = (i == 5);
      to_sample();
      check($sformatf("st%0d_d_gnt", i), 32'(d_gnt), 32'(exp_dg[i]));
      check($sformatf("st%0d_if_gnt", i), 32'(if_gnt), 32'(exp_ig[i]));
      if (exp_dg[i]) check($sformatf("st%0d_mem_we", i), 32'(mem_we), 32'd1);
      if (i == 5) check("st5_if_rvalid", 32'(if_rvalid), 32'd1);
      next_cycle();
    end
    mem_rvalid = 1'b0; if_req = 1'b0; d_req = 1'b0;
    next_cycle();

    // Plain store: masked write, no response expected.
    d_req = 1'b1; d_we = 1'b1; d_wmask = 4'b0011; d_addr = 32'h3000; d_wdata = 32'hDEADBEEF;
    to_sample();
    check("w_d_gnt", 32'(d_gnt), 32'd1);
    check("w_mem_we", 32'(mem_we), 32'd1);
    check("w_mem_wmask", 32'(mem_wmask), 32'h3);
    check("w_mem_wdata", mem_wdata, 32'hDEADBEEF);
    check("w_stall", 32'(stall), 32'd0);
    next_cycle();
    d_req = 1'b0; d_we = 1'b0; mem_rvalid = 1'b1;
    to_sample();
    check("w_d_rvalid", 32'(d_rvalid), 32'd0);
    check("w_idle_stall", 32'(stall), 32'd0);
    next_cycle();

    // Back-pressure on a load.
    mem_rvalid = 1'b0; mem_ready = 1'b0; d_req = 1'b1; d_addr = 32'h4000; d_wmask = 4'h0;
    for (int i = 0; i < 3; i++) begin
      to_sample();
      check($sformatf("bp%0d_d_gnt", i), 32'(d_gnt), 32'd0);
      check($sformatf("bp%0d_stall", i), 32'(stall), 32'd1);
      check($sformatf("bp%0d_mem_addr", i), mem_addr, 32'h4000);
      next_cycle();
    end
    mem_ready = 1'b1;
    to_sample();
    check("bp3_d_gnt", 32'(d_gnt), 32'd1);
    next_cycle();

    // Reset while the load is outstanding; its late response must be dropped.
    d_req = 1'b0; rst_n = 1'b0;
    to_sample();
    check("rr_stall", 32'(stall), 32'd0);
    check("rr_d_rvalid", 32'(d_rvalid), 32'd0);
    next_cycle();
    rst_n = 1'b1; mem_rvalid = 1'b1;
    to_sample();
    check("rr_late_d_rvalid", 32'(d_rvalid), 32'd0);
    check("rr_late_if_rvalid", 32'(if_rvalid), 32'd0);
    check("rr_late_stall", 32'(stall), 32'd0);
    next_cycle();
    mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h200;
    to_sample();
    check("rr_new_if_gnt", 32'(if_gnt), 32'd1);
    check("rr_new_mem_addr", mem_addr, 32'h200);
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
